// File: rtl/safe_lockstep_ctrl.sv
// Lockstep sequencer for NHARTS harts: halt, WFI, sync, lock, resync, exit.
// Optional voter-error counter enabled by SAFE_LOCKSTEP_ERRCNT_EN.
module safe_lockstep_ctrl #(
  parameter int NHARTS         = 3,
  parameter int TIMEOUT_W      = 10,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              safe_mode_i,
  input  logic              dmr_mode_i,
  input  logic [NHARTS-1:0] hart_en_i,
  input  logic [NHARTS-1:0] master_i,
  input  logic [NHARTS-1:0] halt_ack_i,
  input  logic [NHARTS-1:0] wfi_i,
  input  logic [NHARTS-1:0] intc_ack_i,
  input  logic              vote_error_i,
  output logic [NHARTS-1:0] halt_req_o,
  output logic [NHARTS-1:0] sync_irq_o,
  output logic [NHARTS-1:0] resync_irq_o,
  output logic              single_bus_o,
  output logic              voter_en_o,
  output logic              comparator_en_o,
  output logic              busy_o,
  output logic              config_err_o,
  output logic              fault_o,
  output logic [7:0]        err_cnt_o
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_HALT   = 4'd1;
  localparam logic [3:0] S_WFI    = 4'd2;
  localparam logic [3:0] S_SYNC   = 4'd3;
  localparam logic [3:0] S_LOCK   = 4'd4;
  localparam logic [3:0] S_RESYNC = 4'd5;
  localparam logic [3:0] S_RSREL  = 4'd6;
  localparam logic [3:0] S_EXIT   = 4'd7;
  localparam logic [3:0] S_FAULT  = 4'd8;

  localparam logic [TIMEOUT_W-1:0] TO_LAST =
    TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [3:0]           r_state;
  logic [3:0]           w_fsm_next;
  logic [3:0]           w_next;
  logic [TIMEOUT_W-1:0] r_wdog;
  logic [NHARTS-1:0]    r_act;
  logic                 r_dmr;
  logic                 r_cfg_err;

  logic [3:0]           w_pop;
  logic                 w_onehot;
  logic                 w_in_en;
  logic                 w_legal;
  logic                 w_all_halt;
  logic                 w_all_wfi;
  logic                 w_all_ack;
  logic                 w_none_ack;
  logic                 w_mst_ack;
  logic                 w_wd_run;
  logic                 w_tmo;
  logic                 w_start;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NHARTS; i++) begin
      w_pop = w_pop + 4'(hart_en_i[i]);
    end
  end

  assign w_onehot = (master_i != '0) &&
    ((master_i & (master_i - NHARTS'(1))) == '0);
  assign w_in_en  = (master_i & ~hart_en_i) == '0;
  assign w_legal  = w_onehot && w_in_en &&
    (dmr_mode_i ? (w_pop == 4'd2) : (w_pop >= 4'd3));

  assign w_all_halt =
    ((halt_ack_i | master_i) & r_act) == r_act;
  assign w_all_wfi  = (wfi_i & r_act) == r_act;
  assign w_all_ack  = (intc_ack_i & r_act) == r_act;
  assign w_none_ack = (intc_ack_i & r_act) == '0;
  assign w_mst_ack  = (intc_ack_i & master_i) != '0;

  always_comb begin
    w_fsm_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (safe_mode_i && w_legal) w_fsm_next = S_HALT;
      S_HALT:
        if (w_all_halt) w_fsm_next = S_WFI;
      S_WFI:
        if (w_all_wfi) w_fsm_next = S_SYNC;
      S_SYNC:
        if (w_all_ack) w_fsm_next = S_LOCK;
      S_LOCK: begin
        if (vote_error_i) begin
          w_fsm_next = r_dmr ? S_FAULT : S_RESYNC;
        end else if (!safe_mode_i && w_all_wfi) begin
          w_fsm_next = S_EXIT;
        end
      end
      S_RESYNC:
        if (w_all_ack) w_fsm_next = S_RSREL;
      S_RSREL:
        if (w_none_ack) w_fsm_next = S_LOCK;
      S_EXIT:
        if (w_mst_ack) w_fsm_next = S_IDLE;
      S_FAULT:
        if (!safe_mode_i) w_fsm_next = S_IDLE;
      default:
        w_fsm_next = S_IDLE;
    endcase
  end

  // Watchdog guards every handshake state; it outranks normal progress.
  assign w_wd_run = (r_state == S_HALT)   ||
                    (r_state == S_WFI)    ||
                    (r_state == S_SYNC)   ||
                    (r_state == S_RESYNC) ||
                    (r_state == S_RSREL)  ||
                    (r_state == S_EXIT);
  assign w_tmo    = w_wd_run && (r_wdog == TO_LAST);
  assign w_next   = w_tmo ? S_FAULT : w_fsm_next;
  assign w_start  = (r_state == S_IDLE) && (w_next == S_HALT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wdog <= '0;
    end else if (!w_wd_run || (w_next != r_state)) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_act <= '0;
      r_dmr <= 1'b0;
    end else if (w_start) begin
      r_act <= hart_en_i;
      r_dmr <= dmr_mode_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= (r_state == S_IDLE) &&
                   safe_mode_i && !w_legal;
    end
  end

`ifdef SAFE_LOCKSTEP_ERRCNT_EN
  logic       w_vote_hit;
  logic [7:0] r_err_cnt;

  assign w_vote_hit = (r_state == S_LOCK) && vote_error_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_cnt <= '0;
    end else if (w_vote_hit && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt_o = r_err_cnt;
`else
  assign err_cnt_o = '0;
`endif

  always_comb begin
    halt_req_o      = '0;
    sync_irq_o      = '0;
    resync_irq_o    = '0;
    single_bus_o    = 1'b0;
    voter_en_o      = 1'b0;
    comparator_en_o = 1'b0;
    fault_o         = 1'b0;
    unique case (r_state)
      S_HALT:
        halt_req_o = r_act & ~master_i;
      S_SYNC: begin
        sync_irq_o   = r_act;
        single_bus_o = 1'b1;
      end
      S_LOCK: begin
        single_bus_o    = 1'b1;
        voter_en_o      = ~r_dmr;
        comparator_en_o = r_dmr;
      end
      S_RESYNC: begin
        resync_irq_o = r_act;
        single_bus_o = 1'b1;
        voter_en_o   = 1'b1;
      end
      S_RSREL: begin
        single_bus_o = 1'b1;
        voter_en_o   = 1'b1;
      end
      S_EXIT:
        sync_irq_o = master_i;
      S_FAULT:
        fault_o = 1'b1;
      default: ;
    endcase
  end

  assign busy_o       = r_state != S_IDLE;
  assign config_err_o = r_cfg_err;

endmodule

// File: tb/tb_safe_lockstep_ctrl.sv
// Bench for safe_lockstep_ctrl: cycle model plus directed scenarios.
// Model tracks lockstep phase and time-in-phase from the operating rules.
module tb_safe_lockstep_ctrl;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       safe = 1'b0;
  logic       dmr = 1'b0;
  logic [2:0] hart_en = '0;
  logic [2:0] master = '0;
  logic [2:0] halt_ack = '0;
  logic [2:0] wfi = '0;
  logic [2:0] intc_ack = '0;
  logic       vote = 1'b0;

  logic [2:0] halt_req_o;
  logic [2:0] sync_irq_o;
  logic [2:0] resync_irq_o;
  logic       single_bus_o;
  logic       voter_en_o;
  logic       comparator_en_o;
  logic       busy_o;
  logic       config_err_o;
  logic       fault_o;
  logic [7:0] err_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  safe_lockstep_ctrl #(
    .NHARTS(3),
    .TIMEOUT_W(10),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .safe_mode_i(safe),
    .dmr_mode_i(dmr),
    .hart_en_i(hart_en),
    .master_i(master),
    .halt_ack_i(halt_ack),
    .wfi_i(wfi),
    .intc_ack_i(intc_ack),
    .vote_error_i(vote),
    .halt_req_o(halt_req_o),
    .sync_irq_o(sync_irq_o),
    .resync_irq_o(resync_irq_o),
    .single_bus_o(single_bus_o),
    .voter_en_o(voter_en_o),
    .comparator_en_o(comparator_en_o),
    .busy_o(busy_o),
    .config_err_o(config_err_o),
    .fault_o(fault_o),
    .err_cnt_o(err_cnt_o)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  typedef enum {
    M_IDLE, M_HALT, M_WFI, M_SYNC, M_LOCK,
    M_RS, M_RSR, M_EXIT, M_FAULT
  } mst_e;

  mst_e       ms = M_IDLE;
  int         age = 0;
  logic [2:0] mact = '0;
  logic       mdmr = 1'b0;
  int         merr = 0;
  logic       mcfg = 1'b0;

  function automatic bit all_act(input logic [2:0] x);
    return (x & mact) == mact;
  endfunction

  function automatic bit guarded(input mst_e s);
    return s inside {M_HALT, M_WFI, M_SYNC, M_RS, M_RSR, M_EXIT};
  endfunction

  task automatic model_step();
    mst_e nx;
    bit   legal;
    nx = ms;
    mcfg = 1'b0;
    legal = $onehot(master) && ((master & ~hart_en) == 3'b0) &&
            (dmr ? ($countones(hart_en) == 2)
                 : ($countones(hart_en) >= 3));
    case (ms)
      M_IDLE:
        if (safe) begin
          if (legal) nx = M_HALT;
          else mcfg = 1'b1;
        end
      M_HALT: if (all_act(halt_ack | master)) nx = M_WFI;
      M_WFI:  if (all_act(wfi)) nx = M_SYNC;
      M_SYNC: if (all_act(intc_ack)) nx = M_LOCK;
      M_LOCK:
        if (vote) begin
          nx = mdmr ? M_FAULT : M_RS;
          if (merr < 255) merr++;
        end else if (!safe && all_act(wfi)) begin
          nx = M_EXIT;
        end
      M_RS:   if (all_act(intc_ack)) nx = M_RSR;
      M_RSR:  if ((intc_ack & mact) == 3'b0) nx = M_LOCK;
      M_EXIT: if ((intc_ack & master) != 3'b0) nx = M_IDLE;
      M_FAULT: if (!safe) nx = M_IDLE;
      default: nx = M_IDLE;
    endcase
    if (guarded(ms) && (age + 1 >= TMO)) nx = M_FAULT;
    if (ms == M_IDLE && nx == M_HALT) begin
      mact = hart_en;
      mdmr = dmr;
    end
    age = (nx == ms && guarded(ms)) ? age + 1 : 0;
    ms = nx;
  endtask

  task automatic model_check();
    logic [2:0] eh, es, er;
    logic       sb, ve, ce;
    int         ee;
    eh = '0; es = '0; er = '0;
    sb = 1'b0; ve = 1'b0; ce = 1'b0;
    case (ms)
      M_HALT: eh = mact & ~master;
      M_SYNC: begin es = mact; sb = 1'b1; end
      M_LOCK: begin sb = 1'b1; ve = ~mdmr; ce = mdmr; end
      M_RS:   begin er = mact; sb = 1'b1; ve = 1'b1; end
      M_RSR:  begin sb = 1'b1; ve = 1'b1; end
      M_EXIT: es = master;
      default: ;
    endcase
`ifdef SAFE_LOCKSTEP_ERRCNT_EN
    ee = merr;
`else
    ee = 0;
`endif
    chk("m_halt_req", 32'(halt_req_o), 32'(eh));
    chk("m_sync_irq", 32'(sync_irq_o), 32'(es));
    chk("m_resync_irq", 32'(resync_irq_o), 32'(er));
    chk("m_single_bus", 32'(single_bus_o), 32'(sb));
    chk("m_voter_en", 32'(voter_en_o), 32'(ve));
    chk("m_cmp_en", 32'(comparator_en_o), 32'(ce));
    chk("m_busy", 32'(busy_o), 32'(ms != M_IDLE));
    chk("m_cfg_err", 32'(config_err_o), 32'(mcfg));
    chk("m_fault", 32'(fault_o), 32'(ms == M_FAULT));
    chk("m_err_cnt", 32'(err_cnt_o), 32'(ee));
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms = M_IDLE; age = 0; mact = '0;
      mdmr = 1'b0; merr = 0; mcfg = 1'b0;
    end else begin
      model_step();
    end
    #1;
    model_check();
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_in();
    safe = 1'b0; dmr = 1'b0; vote = 1'b0;
    halt_ack = '0; wfi = '0; intc_ack = '0;
  endtask

  function automatic int err_exp(input int n);
`ifdef SAFE_LOCKSTEP_ERRCNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  initial begin
    #100000;
    $display("FAIL global_timeout: sim did not end");
    $fatal(1);
  end

  initial begin
    // Reset state and first cycle after release.
    cyc(1);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_halt", 32'(halt_req_o), 0);
    rst_n = 1'b1;
    cyc(1);
    chk("rel_busy", 32'(busy_o), 0);
    chk("rel_err", 32'(err_cnt_o), 0);

    // TMR sequence with a resync.
    hart_en = 3'b111; master = 3'b001; dmr = 1'b0;
    safe = 1'b1;
    cyc(1);
    chk("tmr_halt_req", 32'(halt_req_o), 32'h6);
    chk("tmr_busy", 32'(busy_o), 1);
    cyc(1);
    halt_ack = 3'b110; wfi = 3'b111;
    cyc(2);
    chk("tmr_sync", 32'(sync_irq_o), 32'h7);
    chk("tmr_sync_bus", 32'(single_bus_o), 1);
    intc_ack = 3'b111;
    cyc(1);
    chk("tmr_lock_voter", 32'(voter_en_o), 1);
    chk("tmr_lock_bus", 32'(single_bus_o), 1);
    chk("tmr_lock_cmp", 32'(comparator_en_o), 0);
    intc_ack = 3'b000;
    cyc(1);
    vote = 1'b1;
    cyc(1);
    vote = 1'b0;
    chk("tmr_resync", 32'(resync_irq_o), 32'h7);
    cyc(1);
    chk("tmr_resync_hold", 32'(resync_irq_o), 32'h7);
    intc_ack = 3'b111;
    cyc(1);
    chk("tmr_rsrel_irq", 32'(resync_irq_o), 0);
    chk("tmr_rsrel_voter", 32'(voter_en_o), 1);
    intc_ack = 3'b000;
    cyc(1);
    chk("tmr_relock", 32'(voter_en_o), 1);
    chk("tmr_err_cnt", 32'(err_cnt_o), 32'(err_exp(1)));
    safe = 1'b0;
    cyc(1);
    chk("tmr_exit_irq", 32'(sync_irq_o), 32'h1);
    intc_ack = 3'b001;
    cyc(1);
    chk("tmr_idle", 32'(busy_o), 0);
    clr_in();

    // DMR lock, compare error, fault, release.
    hart_en = 3'b011; master = 3'b010; dmr = 1'b1;
    halt_ack = 3'b001; wfi = 3'b011; intc_ack = 3'b011;
    safe = 1'b1;
    cyc(1);
    chk("dmr_halt_req", 32'(halt_req_o), 32'h1);
    cyc(2);
    chk("dmr_sync", 32'(sync_irq_o), 32'h3);
    chk("dmr_not_yet", 32'(comparator_en_o), 0);
    cyc(1);
    chk("dmr_cmp_en", 32'(comparator_en_o), 1);
    chk("dmr_voter", 32'(voter_en_o), 0);
    intc_ack = 3'b000; vote = 1'b1;
    cyc(1);
    vote = 1'b0;
    chk("dmr_fault", 32'(fault_o), 1);
    chk("dmr_fault_bus", 32'(single_bus_o), 0);
    chk("dmr_err_cnt", 32'(err_cnt_o), 32'(err_exp(2)));
    cyc(1);
    chk("dmr_fault_hold", 32'(fault_o), 1);
    safe = 1'b0;
    cyc(1);
    chk("dmr_fault_clr", 32'(fault_o), 0);
    chk("dmr_idle", 32'(busy_o), 0);
    clr_in();

    // Illegal config: TMR with only two harts.
    hart_en = 3'b011; master = 3'b001; safe = 1'b1;
    cyc(1);
    chk("ill_cfg_err", 32'(config_err_o), 1);
    chk("ill_busy", 32'(busy_o), 0);
    chk("ill_halt", 32'(halt_req_o), 0);
    cyc(1);
    chk("ill_cfg_err2", 32'(config_err_o), 1);
    safe = 1'b0;
    cyc(1);
    chk("ill_cfg_clr", 32'(config_err_o), 0);
    clr_in();

    // Watchdog: hart 2 never acks the halt.
    hart_en = 3'b111; master = 3'b001; halt_ack = 3'b010;
    safe = 1'b1;
    cyc(1);
    cyc(15);
    chk("tmo_pre_fault", 32'(fault_o), 0);
    chk("tmo_pre_halt", 32'(halt_req_o), 32'h6);
    cyc(1);
    chk("tmo_fault_16", 32'(fault_o), 1);
    safe = 1'b0;
    cyc(1);
    chk("tmo_idle", 32'(busy_o), 0);
    clr_in();

    // Reset asserted while in RESYNC.
    hart_en = 3'b111; master = 3'b001;
    halt_ack = 3'b110; wfi = 3'b111; intc_ack = 3'b111;
    safe = 1'b1;
    cyc(4);
    chk("rr_lock", 32'(voter_en_o), 1);
    intc_ack = 3'b000; vote = 1'b1;
    cyc(1);
    vote = 1'b0;
    chk("rr_resync", 32'(resync_irq_o), 32'h7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_rst_resync", 32'(resync_irq_o), 0);
    chk("rr_rst_bus", 32'(single_bus_o), 0);
    chk("rr_rst_busy", 32'(busy_o), 0);
    chk("rr_rst_err", 32'(err_cnt_o), 0);
    cyc(2);
    safe = 1'b0;
    rst_n = 1'b1;
    cyc(1);
    chk("rr_rel_busy", 32'(busy_o), 0);
    chk("rr_rel_voter", 32'(voter_en_o), 0);
    clr_in();
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/safe_lockstep_ctrl.md
# safe_lockstep_ctrl

Parametrised lockstep controller for the safety cluster. It generalises the fixed 3-hart TMR/DMR sequencer to NHARTS harts with a runtime participation mask and a per-state watchdog timeout. In TMR mode it resynchronises the group after a voter error; in DMR mode a compare error escalates to a fault. It sits between the debug/interrupt fabric of the harts and the voter/comparator and bus-merge logic.

## Interface
- NHARTS, 3, number of harts; legal range 2..8.
- TIMEOUT_W, 10, watchdog counter width.
- TIMEOUT_CYCLES, 1000, watchdog limit; must be < 2**TIMEOUT_W and > 0.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- safe_mode_i  in  1  request lockstep (1) or release (0).
- dmr_mode_i  in  1  1 = DMR, 0 = TMR; sampled in IDLE only.
- hart_en_i  in  NHARTS  participating harts; sampled in IDLE only.
- master_i  in  NHARTS  one-hot master hart.
- halt_ack_i, wfi_i, intc_ack_i  in  NHARTS each  per-hart debug-halt ack, WFI status, interrupt ack.
- vote_error_i  in  1  voter/comparator mismatch, valid only in LOCK.
- halt_req_o, sync_irq_o, resync_irq_o  out  NHARTS each  per-hart halt request, sync interrupt, resync interrupt.
- single_bus_o, voter_en_o, comparator_en_o  out  1 each  bus merge, TMR voter enable, DMR comparator enable.
- busy_o  out  1  state != IDLE.
- config_err_o, fault_o  out  1 each  one-cycle illegal-config pulse; level while in FAULT.
- err_cnt_o  out  8  voter-error count (see Configuration).

## Operation
- Active set act_q and mode dmr_q are registered on the IDLE->HALT transition; unchanged until IDLE re-entered. all(x) means (x & act_q) == act_q.
- Legal config: master_i one-hot and within hart_en_i; popcount(hart_en_i) >= 3 for TMR, == 2 for DMR.
- States and transitions:
  - IDLE: safe_mode_i=1 and legal -> HALT; safe_mode_i=1 and illegal -> stay, config_err_o pulses each such cycle.
  - HALT: halt_req_o = act_q & ~master_i. all(halt_ack_i | master_i) -> WAIT_WFI.
  - WAIT_WFI: all(wfi_i) -> SYNC.
  - SYNC: sync_irq_o = act_q; single_bus_o=1. all(intc_ack_i) -> LOCK.
  - LOCK: single_bus_o=1; voter_en_o = ~dmr_q; comparator_en_o = dmr_q. vote_error_i=1: TMR -> RESYNC, DMR -> FAULT. Else safe_mode_i=0 and all(wfi_i) -> EXIT. vote_error_i has priority over exit.
  - RESYNC: resync_irq_o = act_q; single_bus_o=1; voter_en_o=1. all(intc_ack_i) -> RESYNC_REL.
  - RESYNC_REL: single_bus_o=1; voter_en_o=1. no act hart has intc_ack_i -> LOCK.
  - EXIT: sync_irq_o = master_i. master intc_ack_i -> IDLE.
  - FAULT: fault_o=1, all other outputs 0. safe_mode_i=0 -> IDLE.
- Watchdog: counter cleared on every state change and in IDLE, LOCK, FAULT; increments in other states. Reaching TIMEOUT_CYCLES -> FAULT next edge; timeout wins over any simultaneous transition.
- safe_mode_i falling in HALT..SYNC is ignored; sequence completes to LOCK first.

## Timing
- All outputs decoded from registered state (Moore); an input causing a transition affects outputs on the cycle after the edge.
- safe_mode_i high in IDLE at edge N -> halt_req_o high from N+1.
- Minimum IDLE->LOCK: 4 cycles with all acks already high.
- Reset (including mid-sequence): state IDLE, counter 0, act_q 0, dmr_q 0, err_cnt 0; every output 0 while rst_ni low and on the first cycle after release.

## Configuration
- SAFE_LOCKSTEP_ERRCNT_EN defined: 8-bit saturating counter increments on each LOCK->RESYNC or LOCK->FAULT transition due to vote_error_i, holds at 255, cleared only by reset; drives err_cnt_o.
- Undefined: no counter logic; err_cnt_o tied to 0.

## Test plan
- NHARTS=3, TMR, all enabled, master=001: safe_mode_i=1, acks after 2 cycles -> halt_req_o=110, then sync_irq_o=111, LOCK with voter_en_o=1, single_bus_o=1.
- In LOCK, vote_error_i pulse -> resync_irq_o=111 until all intc_ack; return to LOCK after acks drop; err_cnt_o=1 with macro, 0 without.
- DMR, hart_en_i=011, master=010: enter LOCK, comparator_en_o=1; vote_error_i=1 -> fault_o=1; safe_mode_i=0 -> IDLE.
- Illegal config (TMR, hart_en_i=011) -> config_err_o high, busy_o=0, no halt_req_o.
- TIMEOUT_CYCLES=16, withhold one halt_ack -> FAULT exactly 16 cycles after HALT entry.
- Assert rst_ni low in RESYNC -> all outputs 0 immediately; idle after release.
